// File: rtl/ramp_sequencer.sv
// ramp_sequencer: per-channel DAC amplitude ramp (idle/up/hold/down) with bypass scale output
module ramp_sequencer #(
  parameter int ACC_WIDTH   = 32,
  parameter int SCALE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   ramping_enable,
  input  logic                   start_ramp_down,
  input  logic                   synth_aresetn,
  input  logic [ACC_WIDTH-1:0]   ramp_inc,
  output logic [SCALE_WIDTH-1:0] scale,
  output logic [1:0]             ramp_state,
  output logic                   ramp_done
);
  typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, HOLD = 2'b10, DOWN = 2'b11} state_t;
  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d, inc_q, inc_d;
  logic [SCALE_WIDTH-1:0] scale_q, scale_d;
  logic                   synth_q, done_q, done_d;
  logic [ACC_WIDTH:0]     sum, dif;
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, inc_q};
    dif     = {1'b0, acc_q} - {1'b0, inc_q};
    state_d = state_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    done_d  = 1'b0;
    scale_d = ramping_enable ? acc_q[ACC_WIDTH-1 -: SCALE_WIDTH] : '1;
    if (!synth_aresetn || !ramping_enable) begin
      state_d = IDLE;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          acc_d = '0;
          if (synth_aresetn && !synth_q && !start_ramp_down) begin
            state_d = UP;
            inc_d   = ramp_inc;
          end
        end
        // a ramp-down request in UP starts DOWN from the current level without stepping
        UP: begin
          if (start_ramp_down) state_d = DOWN;
          else if (sum[ACC_WIDTH]) begin
            acc_d   = '1;
            state_d = HOLD;
          end else acc_d = sum[ACC_WIDTH-1:0];
        end
        HOLD: begin
          acc_d = '1;
          if (start_ramp_down) state_d = DOWN;
        end
        DOWN: begin
          if (dif[ACC_WIDTH] || dif[ACC_WIDTH-1:0] == '0) begin
            acc_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else acc_d = dif[ACC_WIDTH-1:0];
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      inc_q   <= '0;
      synth_q <= 1'b0;
      scale_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      synth_q <= synth_aresetn;
      scale_q <= scale_d;
      done_q  <= done_d;
    end
  end
  assign scale      = scale_q;
  assign ramp_state = state_q;
  assign ramp_done  = done_q;
endmodule

// File: tb/tb_ramp_sequencer.sv
// tb_ramp_sequencer: directed and randomized checks of ramp_sequencer against a level-based reference model
module tb_ramp_sequencer;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        en = 1'b1, srd = 1'b0, syn = 1'b0;
  logic [31:0] inc = 32'h4000_0000;
  logic [15:0] scale;
  logic [1:0]  ramp_state;
  logic        ramp_done;
  int          n_chk = 0, n_err = 0;
  longint      m_lvl, m_step;
  int          m_mode;
  bit          m_prev, m_done;
  logic [15:0] m_scale;
  ramp_sequencer dut (
    .clk(clk), .aresetn(aresetn), .ramping_enable(en), .start_ramp_down(srd),
    .synth_aresetn(syn), .ramp_inc(inc), .scale(scale), .ramp_state(ramp_state),
    .ramp_done(ramp_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_lvl = 0; m_step = 0; m_mode = 0; m_prev = 0; m_done = 0; m_scale = 16'h0000;
  endtask
  // amplitude level modelled as an unbounded integer clamped to [0, 2^32-1]
  task automatic m_clock();
    longint full = 64'hFFFF_FFFF;
    m_scale = en ? 16'(m_lvl >> 16) : 16'hFFFF;
    m_done  = 0;
    if (!syn || !en) begin
      m_mode = 0; m_lvl = 0;
    end else if (m_mode == 0) begin
      m_lvl = 0;
      if (!m_prev && !srd) begin m_mode = 1; m_step = longint'(inc); end
    end else if (m_mode == 1) begin
      if (srd) m_mode = 3;
      else if (m_lvl + m_step > full) begin m_lvl = full; m_mode = 2; end
      else m_lvl = m_lvl + m_step;
    end else if (m_mode == 2) begin
      if (srd) m_mode = 3;
    end else if (m_lvl <= m_step) begin
      m_lvl = 0; m_mode = 0; m_done = 1;
    end else m_lvl = m_lvl - m_step;
    m_prev = syn;
  endtask
  task automatic cyc(input logic e, input logic s, input logic y, input logic [31:0] i);
    en = e; srd = s; syn = y; inc = i;
    @(posedge clk);
    m_clock();
    #1;
    chk("state", 32'(ramp_state), 32'(m_mode));
    chk("scale", 32'(scale), 32'(m_scale));
    chk("done", 32'(ramp_done), 32'(m_done));
  endtask
  task automatic arst_check(input string tag);
    chk({tag, "_state"}, 32'(ramp_state), 0);
    chk({tag, "_scale"}, 32'(scale), 0);
    chk({tag, "_done"}, 32'(ramp_done), 0);
  endtask
  initial begin
    logic [31:0] pick;
    m_reset();
    #1 arst_check("rst");
    #11 aresetn = 1'b1;
    cyc(1, 0, 0, 32'h4000_0000);
    cyc(1, 0, 1, 32'h4000_0000);
    chk("up_enter", 32'(ramp_state), 1);
    cyc(1, 0, 1, 32'h1234_5678);
    cyc(1, 0, 1, 32'h1234_5678);
    chk("up_s1", 32'(scale), 32'h4000);
    cyc(1, 0, 1, 32'h1234_5678);
    chk("up_s2", 32'(scale), 32'h8000);
    cyc(1, 0, 1, 32'h1234_5678);
    chk("up_s3", 32'(scale), 32'hC000);
    chk("up_sat", 32'(ramp_state), 2);
    cyc(1, 0, 1, 32'h1234_5678);
    chk("up_full", 32'(scale), 32'hFFFF);
    cyc(1, 1, 1, 32'h4000_0000);
    chk("dn_enter", 32'(ramp_state), 3);
    repeat (3) cyc(1, 1, 1, 32'h4000_0000);
    chk("dn_s", 32'(scale), 32'h7FFF);
    cyc(1, 1, 1, 32'h4000_0000);
    chk("dn_done", 32'(ramp_done), 1);
    chk("dn_idle", 32'(ramp_state), 0);
    cyc(1, 1, 1, 32'h4000_0000);
    chk("dn_zero", 32'(scale), 32'h0000);
    chk("dn_pulse", 32'(ramp_done), 0);
    cyc(1, 1, 0, 32'h4000_0000);
    cyc(1, 1, 1, 32'h4000_0000);
    chk("rearm_blk", 32'(ramp_state), 0);
    cyc(1, 0, 0, 32'h1000_0000);
    repeat (4) cyc(1, 0, 1, 32'h1000_0000);
    cyc(1, 1, 1, 32'h1000_0000);
    chk("abort_dn", 32'(ramp_state), 3);
    cyc(1, 1, 1, 32'h1000_0000);
    chk("abort_nojump", 32'(scale), 32'h3000);
    cyc(1, 1, 1, 32'h1000_0000);
    cyc(1, 1, 1, 32'h1000_0000);
    chk("abort_s", 32'(scale), 32'h1000);
    chk("abort_done", 32'(ramp_done), 1);
    cyc(1, 0, 0, 32'h4000_0000);
    repeat (6) cyc(1, 0, 1, 32'h4000_0000);
    chk("hold", 32'(ramp_state), 2);
    cyc(1, 0, 0, 32'h4000_0000);
    chk("sreset_st", 32'(ramp_state), 0);
    chk("sreset_done", 32'(ramp_done), 0);
    cyc(1, 0, 0, 32'h4000_0000);
    chk("sreset_scale", 32'(scale), 32'h0000);
    for (int k = 0; k < 8; k++) cyc(0, 0, k[1], 32'h4000_0000);
    chk("byp_scale", 32'(scale), 32'hFFFF);
    repeat (3) cyc(1, 0, 1, 32'h2000_0000);
    cyc(1, 0, 0, 32'h2000_0000);
    repeat (3) cyc(1, 0, 1, 32'h2000_0000);
    cyc(0, 0, 1, 32'h2000_0000);
    chk("byp_up_st", 32'(ramp_state), 0);
    chk("byp_up_sc", 32'(scale), 32'hFFFF);
    cyc(1, 0, 0, 32'h1000_0000);
    repeat (4) cyc(1, 0, 1, 32'h1000_0000);
    #2 aresetn = 1'b0;
    #1 arst_check("arst");
    m_reset();
    @(posedge clk);
    #1 arst_check("arst_hold");
    aresetn = 1'b1;
    cyc(1, 0, 1, 32'h4000_0000);
    chk("arst_restart", 32'(ramp_state), 1);
    for (int k = 0; k < 4000; k++) begin
      logic e, s, y;
      e = en; s = srd; y = syn; pick = inc;
      if ($urandom_range(99) < 3) e = ~e;
      if ($urandom_range(99) < 8) y = ~y;
      if ($urandom_range(99) < 6) s = ~s;
      if ($urandom_range(99) < 20)
        case ($urandom_range(4))
          0: pick = 32'h4000_0000;
          1: pick = 32'h1000_0000;
          2: pick = 32'h0;
          default: pick = $urandom_range(32'hFFFF_FFFF, 32'h0200_0000);
        endcase
      cyc(e, s, y, pick);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ramp_sequencer.md
# ramp_sequencer

Per-channel DAC amplitude ramp controller, instantiated once per output channel. It sits between the PS ramping configuration (enable / start-ramp-down bits) and the DAC synthesis path, and produces a 16-bit amplitude scale that ramps up after the synthesizer leaves reset, holds, and ramps down on request. It also provides the 2-bit ramp state reported in the reset/status word.

## Interface
Parameters:
- ACC_WIDTH, 32, phase-accumulator width. The increment input has the same width.
- SCALE_WIDTH, 16, output scale width. The scale is taken as acc[ACC_WIDTH-1 -: SCALE_WIDTH].

Ports:
- clk  in  1  DAC/ADC clock, 125 MHz.
- aresetn  in  1  reset, asynchronous, active-low. One clock domain only.
- ramping_enable  in  1  ramping enabled for this channel (level).
- start_ramp_down  in  1  request ramp down (level).
- synth_aresetn  in  1  synthesizer reset of this channel. High means the synthesizer is running.
- ramp_inc  in  ACC_WIDTH  accumulator step per clock. It is latched on entry to UP.
- scale  out  SCALE_WIDTH  amplitude multiplier; 0xFFFF represents full scale. Registered.
- ramp_state  out  2  encoding: 00 IDLE, 01 UP, 10 HOLD, 11 DOWN. Registered.
- ramp_done  out  1  one-cycle pulse when DOWN reaches zero.

## Operation
- Internal registers:
  - acc [ACC_WIDTH]
  - inc_l [ACC_WIDTH]: latched increment
  - synth_d: previous synth_aresetn
  - 2-bit state
- Definition: start edge = synth_aresetn & ~synth_d.
- IDLE:
  - acc = 0.
  - Go to UP when ramping_enable=1, start_ramp_down=0 and a start edge occurs. On this transition, inc_l <= ramp_inc.
- UP:
  - Computation: {c, s} = acc + inc_l.
  - If c=1, acc <= all-ones and go to HOLD.
  - Otherwise acc <= s and stay in UP.
- HOLD:
  - acc stays all-ones.
  - Go to DOWN when start_ramp_down=1.
- DOWN:
  - Computation: {b, d} = acc - inc_l.
  - If b=1 or d=0, acc <= 0, go to IDLE, and pulse ramp_done.
  - Otherwise acc <= d.
- Priority, highest first; higher-priority events override lower ones in the same cycle:
  1. synth_aresetn=0: go to IDLE, acc <= 0, no ramp_done pulse.
  2. ramping_enable=0: go to IDLE, acc <= 0.
  3. start_ramp_down=1 while in UP: go to DOWN next cycle, starting from the current acc. No jump. This takes precedence over the saturation step.
  4. Normal transitions as listed above.
- scale output:
  - When ramping_enable=0: scale = all-ones (bypass, full amplitude).
  - Otherwise: scale = acc[top SCALE_WIDTH bits].
- inc_l=0:
  - UP never saturates; scale stays 0 until the ramp is aborted or start_ramp_down is asserted.
  - In DOWN, a zero increment with acc≠0 never terminates. Software must program a non-zero value.
- Re-arm: after DOWN completes, a new ramp needs start_ramp_down=0 and a fresh start edge (the synthesizer must go through reset again).

## Timing
- Reset values:
  - state IDLE (00)
  - acc 0, inc_l 0
  - synth_d 0
  - scale 0x0000
  - ramp_done 0
- scale and ramp_state are registered.
- Latency:
  - Inputs affect state, acc and ramp_done at the next clk edge.
  - scale reflects acc one cycle later.
- If synth_aresetn is already high when aresetn is released, the first clk edge sees a start edge (synth_d resets to 0). This is required behaviour.
- Ramp duration up: ceil((2^ACC_WIDTH − 1) / inc_l) cycles in UP, including the saturating cycle. Ramp down is symmetric.
- Reset mid-ramp (aresetn low): all outputs go to reset values immediately (asynchronous), with no pulse.
- Status integration: ramp_state maps to reset_sts[18:17] for ch0 and reset_sts[22:21] for ch1.

## Test plan
- Basic ramp up:
  - Stimulus: enable=1, ramp_inc=0x4000_0000, synth_aresetn 0→1.
  - Required: ramp_state goes 01. scale goes 0x4000, 0x8000, 0xC000, 0xFFFF on consecutive cycles. ramp_state goes 10 on the saturating cycle.
- Ramp down:
  - Stimulus: from HOLD with inc=0x4000_0000, start_ramp_down=1.
  - Required: state 11. scale goes 0xBFFF, 0x7FFF, 0x3FFF, 0x0000. One ramp_done pulse on the zero cycle. State returns to 00.
- Abort in UP:
  - Stimulus: inc=0x1000_0000; assert start_ramp_down after 3 UP cycles (acc=0x3000_0000).
  - Required: DOWN with scale 0x2000, 0x1000, 0x0000, then ramp_done.
- Synthesizer reset mid-ramp:
  - Stimulus: synth_aresetn=0 in HOLD.
  - Required: next cycle state 00 and scale 0x0000, with no ramp_done pulse.
- Bypass:
  - Stimulus: enable=0 with synth toggling.
  - Required: scale=0xFFFF constantly and state 00. Deasserting enable mid-UP gives state 00 and scale 0xFFFF.
- Re-arm and reset:
  - Stimulus: a start edge while start_ramp_down=1.
  - Required: stays IDLE.
  - Stimulus: aresetn pulsed low during UP.
  - Required: all outputs return to reset values asynchronously.
